led_matrix_scanner: RTL and testbench
=====================================

// Module: led_matrix_scanner
// PURPOSE
//  Input-side counterpart of the LED array driver: scans an N x N switch/button matrix one column
//  at a time, samples the row sense lines, debounces whole frames, and publishes a debounced
//  N*N cell vector (same bit mapping the Conway grid uses) for loading/editing the game state.
//  Sits between the board pins and the Conway cell register; one clock domain.
// PARAMETERS
//  N               5  grid size; 1..8 ($error otherwise)
//  SETTLE_CYCLES   4  cycles a column is driven before rows are sampled; >=2 ($error otherwise)
//  DEBOUNCE_SCANS  3  consecutive identical frames required before cells updates; >=1
// PORTS
//  clk          in   1          system clock, all state on posedge
//  rst          in   1          asynchronous, active-high reset
//  ena          in   1          scan enable; level-sensitive
//  rows         in   N          row sense lines, active-high, asynchronous (2-flop synced inside)
//  cols         out  N          one-hot column drive, active-high; all-zero when not scanning
//  x            out  $clog2(N)+1  index of column currently driven (0..N-1)
//  cells        out  N*N        debounced matrix; cells[r*N+c] = row r, column c
//  cells_valid  out  1          one-cycle pulse when cells takes a new, different value
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, cols=0, x=0, cells=0, cells_valid=0, frame=0,
//   prev_frame=0, stable_cnt=0, settle_cnt=0, row synchronizer flops=0.
//  rows_s = rows through 2 flops; all sampling uses rows_s only.
//  FSM states: IDLE, DRIVE, SAMPLE, COMPARE.
//   IDLE:    cols=0. ena=1 -> DRIVE next cycle with x=0, settle_cnt=0.
//   DRIVE:   cols=1<<x; settle_cnt++ each cycle; after SETTLE_CYCLES cycles -> SAMPLE.
//   SAMPLE:  cols=1<<x, one cycle; frame[r*N+x] <= rows_s[r] for all r.
//            x<N-1 -> x+1, DRIVE; x==N-1 -> COMPARE (cols=0 in COMPARE).
//   COMPARE: one cycle. frame==prev_frame -> stable_cnt=min(stable_cnt+1,DEBOUNCE_SCANS);
//            else stable_cnt=1, prev_frame<=frame.
//            If resulting stable_cnt==DEBOUNCE_SCANS and frame!=cells: cells<=frame,
//            cells_valid=1 in the following cycle only. Then x=0; ena ? DRIVE : IDLE.
//  Frame length: N*(SETTLE_CYCLES+1)+1 cycles. cells changes at most once per frame.
//  ena=0 in DRIVE/SAMPLE: abort to IDLE next edge; partial frame discarded, stable_cnt=0,
//   cells and prev_frame held. ena=0 in COMPARE: compare completes normally, then IDLE.
//  Stable frame equal to current cells: no pulse, no update (incl. all-zero after reset).
//  Glitch shorter than one frame that differs from prev_frame restarts the count at 1.
//  cols is always one-hot or zero; x never exceeds N-1.
//  rst mid-scan: everything returns to reset values immediately, cells_valid never glitches.
// TESTING  (N=5, SETTLE_CYCLES=2, DEBOUNCE_SCANS=3; frame=16 cycles; cycle 0 = first DRIVE)
//  1 Reset then ena=1, rows model presses (r1,c3) only -> cols walks 00001..10000 every 3
//    cycles; cells_valid pulses once at cycle 48 with cells=1<<8; no other pulse for 10 frames.
//  2 Idle matrix (no presses) for 10 frames -> cells stays 0, cells_valid never asserts.
//  3 Press (r4,c4) for 2 frames then release -> no cells change; hold 3 frames -> cells=1<<24.
//  4 Alternate two patterns each frame -> stable_cnt never reaches 3, cells unchanged.
//  5 Drop ena mid-frame (x=2, DRIVE), re-raise 5 cycles later -> cols=0 while IDLE, scan
//    restarts at x=0, next update needs 3 fresh full identical frames.
//  6 Assert rst during SAMPLE with cells!=0 -> same cycle cells=0, cols=0, x=0, cells_valid=0.

Source files
------------

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: scans an N x N switch matrix one column at a time and
//   publishes a whole-frame debounced cell vector, cells[r*N+c] = row r, col c.
// Latency: one frame = N*(SETTLE_CYCLES+1)+1 cycles; an update needs
//   DEBOUNCE_SCANS identical frames and cells_valid pulses the cycle after.
// Backpressure: none; ena=0 aborts a partial frame and parks the scanner in IDLE.
// Ports:
//   clk, rst            system clock, async active-high reset
//   ena                 level-sensitive scan enable
//   rows[N]             async row sense lines (synchronised inside)
//   cols[N], x          one-hot column drive and its index
//   cells[N*N]          debounced matrix, cells_valid pulses on each change
module led_matrix_scanner #(
  parameter int N              = 5,
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [N-1:0]       rows,
  output logic [N-1:0]       cols,
  output logic [$clog2(N):0] x,
  output logic [N*N-1:0]     cells,
  output logic               cells_valid
);

  localparam int XW  = $clog2(N) + 1;
  localparam int SCW = $clog2(SETTLE_CYCLES + 1);
  localparam int DW  = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [XW-1:0]  X_LAST      = XW'(N - 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0]  STABLE_MAX  = DW'(DEBOUNCE_SCANS);

  if (N < 1 || N > 8) begin : g_bad_n
    $error("led_matrix_scanner: N must be in 1..8");
  end
  if (SETTLE_CYCLES < 2) begin : g_bad_settle
    $error("led_matrix_scanner: SETTLE_CYCLES must be >= 2");
  end
  if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
    $error("led_matrix_scanner: DEBOUNCE_SCANS must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    SAMPLE  = 2'd2,
    COMPARE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [SCW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [DW-1:0]    stable_cnt_q, stable_cnt_d;
  logic [DW-1:0]    stable_nxt;
  logic [N*N-1:0]   frame_q, frame_d;
  logic [N*N-1:0]   prev_frame_q, prev_frame_d;
  logic [N*N-1:0]   cells_q, cells_d;
  logic             cells_valid_q, cells_valid_d;
  logic [N-1:0]     rows_m_q, rows_m_d;
  logic [N-1:0]     rows_s_q, rows_s_d;
  logic             frame_same;

  // State register (all flops share the same async reset)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      x_q           <= '0;
      settle_cnt_q  <= '0;
      stable_cnt_q  <= '0;
      frame_q       <= '0;
      prev_frame_q  <= '0;
      cells_q       <= '0;
      cells_valid_q <= 1'b0;
      rows_m_q      <= '0;
      rows_s_q      <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      settle_cnt_q  <= settle_cnt_d;
      stable_cnt_q  <= stable_cnt_d;
      frame_q       <= frame_d;
      prev_frame_q  <= prev_frame_d;
      cells_q       <= cells_d;
      cells_valid_q <= cells_valid_d;
      rows_m_q      <= rows_m_d;
      rows_s_q      <= rows_s_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ena) state_d = DRIVE;
      DRIVE: begin
        if (!ena)                             state_d = IDLE;
        else if (settle_cnt_q == SETTLE_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (!ena)                 state_d = IDLE;
        else if (x_q == X_LAST)   state_d = COMPARE;
        else                      state_d = DRIVE;
      end
      COMPARE: state_d = ena ? DRIVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: a column is driven only while it is settling or being sampled
  always_comb begin
    cols = '0;
    for (int c = 0; c < N; c++) begin
      cols[c] = ((state_q == DRIVE) || (state_q == SAMPLE)) && (x_q == XW'(c));
    end
  end

  assign x           = x_q;
  assign cells       = cells_q;
  assign cells_valid = cells_valid_q;

  // Debounce count after this frame: saturate on a repeat, restart at 1 on change
  assign frame_same = (frame_q == prev_frame_q);
  always_comb begin
    if (!frame_same)                     stable_nxt = DW'(1);
    else if (stable_cnt_q == STABLE_MAX) stable_nxt = stable_cnt_q;
    else                                 stable_nxt = stable_cnt_q + 1'b1;
  end

  // Datapath next values
  always_comb begin
    x_d           = x_q;
    settle_cnt_d  = settle_cnt_q;
    stable_cnt_d  = stable_cnt_q;
    frame_d       = frame_q;
    prev_frame_d  = prev_frame_q;
    cells_d       = cells_q;
    cells_valid_d = 1'b0;
    rows_m_d      = rows;
    rows_s_d      = rows_m_q;

    unique case (state_q)
      IDLE: begin
        x_d          = '0;
        settle_cnt_d = '0;
      end
      DRIVE: begin
        if (!ena) begin
          // Abort: the partial frame is simply overwritten by the next full scan
          x_d          = '0;
          settle_cnt_d = '0;
          stable_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      SAMPLE: begin
        settle_cnt_d = '0;
        if (!ena) begin
          x_d          = '0;
          stable_cnt_d = '0;
        end else begin
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
              if (x_q == XW'(c)) frame_d[r*N+c] = rows_s_q[r];
            end
          end
          if (x_q != X_LAST) x_d = x_q + 1'b1;
        end
      end
      COMPARE: begin
        stable_cnt_d = stable_nxt;
        if (!frame_same) prev_frame_d = frame_q;
        // Only a change of the published value is worth a pulse
        if ((stable_nxt == STABLE_MAX) && (frame_q != cells_q)) begin
          cells_d       = frame_q;
          cells_valid_d = 1'b1;
        end
        x_d          = '0;
        settle_cnt_d = '0;
      end
      default: begin
        x_d          = '0;
        settle_cnt_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: scoreboard bench for led_matrix_scanner with N=5,
//   SETTLE_CYCLES=2, DEBOUNCE_SCANS=3 (16-cycle frames); a board model
//   closes the loop from cols to rows according to the pressed-key map.
module tb_led_matrix_scanner;

  localparam int N  = 5;
  localparam int SC = 2;
  localparam int DB = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              ena;
  logic [N-1:0]      rows;
  logic [N-1:0]      cols;
  logic [$clog2(N):0] x;
  logic [N*N-1:0]    cells;
  logic              cells_valid;

  logic [N*N-1:0]    press;
  int                cyc    = 0;
  int                base   = 0;
  int                n_chk  = 0;
  int                n_pass = 0;

  typedef struct {
    logic [N*N-1:0] cells;
    int             cyc;
  } exp_t;
  exp_t sb[$];

  led_matrix_scanner #(
    .N              (N),
    .SETTLE_CYCLES  (SC),
    .DEBOUNCE_SCANS (DB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .rows        (rows),
    .cols        (cols),
    .x           (x),
    .cells       (cells),
    .cells_valid (cells_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Board model: a pressed key shorts its column drive onto its row line
  always_comb begin
    rows = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (cols[c] && press[r*N+c]) rows[r] = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic expect_pulse(input logic [N*N-1:0] v, input int c);
    exp_t e;
    e.cells = v;
    e.cyc   = c;
    sb.push_back(e);
  endtask

  // Cycle indices are relative to the first DRIVE cycle of the current scan
  task automatic wait_to(input int c);
    while (cyc < base + c) @(negedge clk);
  endtask

  // Called at a negedge; the next cycle is DRIVE cycle 0
  task automatic start_scan();
    ena  = 1'b1;
    base = cyc + 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    ena   = 1'b0;
    press = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Output monitor: invariants every cycle, pulses popped from the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      chk("cols_onehot0", 64'($onehot0(cols)), 64'd1);
      chk("x_range", 64'(x < N), 64'd1);
      if (cells_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_vld", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("vld_cells", 64'(cells), 64'(e.cells));
          chk("vld_cyc", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin
    logic [N*N-1:0] one;
    logic [N-1:0]   ecols;
    one   = 1;
    rst   = 1'b1;
    ena   = 1'b0;
    press = '0;
    #1;
    chk("rst_cells", 64'(cells), 64'd0);
    chk("rst_cols", 64'(cols), 64'd0);
    chk("rst_x", 64'(x), 64'd0);
    chk("rst_vld", 64'(cells_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: single key (r1,c3), column walk timing and first publish at cycle 48
    press = one << 8;
    start_scan();
    expect_pulse(one << 8, base + 48);
    for (int k = 0; k < 16; k++) begin
      wait_to(k);
      ecols = (k == 15) ? '0 : (N'(1) << (k / 3));
      chk("t1_cols", 64'(cols), 64'(ecols));
      if (k < 15) chk("t1_x", 64'(x), 64'(k / 3));
    end
    wait_to(48 + 16 * 10);
    chk("t1_cells", 64'(cells), 64'(one << 8));
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);

    // 2: idle matrix, all-zero frames equal reset cells
    do_reset();
    start_scan();
    wait_to(16 * 10);
    chk("t2_cells", 64'(cells), 64'd0);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);

    // 3: two-frame press is filtered; three-frame press is published
    do_reset();
    press = one << 24;
    start_scan();
    wait_to(31);
    press = '0;
    wait_to(79);
    press = one << 24;
    expect_pulse(one << 24, base + 128);
    wait_to(100);
    chk("t3_cells_mid", 64'(cells), 64'd0);
    wait_to(160);
    chk("t3_cells", 64'(cells), 64'(one << 24));
    chk("t3_sb_empty", 64'(sb.size()), 64'd0);

    // 4: alternating patterns never settle
    do_reset();
    press = one << 0;
    start_scan();
    for (int k = 1; k < 8; k++) begin
      wait_to(16 * k - 1);
      press = (k % 2 == 1) ? (one << 11) : (one << 0);
    end
    wait_to(16 * 9);
    chk("t4_cells", 64'(cells), 64'd0);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);

    // 5: abort at x=2 DRIVE after two stable frames, then restart
    do_reset();
    press = one << 17;
    start_scan();
    wait_to(38);
    chk("t5_cols_pre", 64'(cols), 64'd4);
    chk("t5_x_pre", 64'(x), 64'd2);
    ena = 1'b0;
    for (int k = 39; k <= 43; k++) begin
      wait_to(k);
      chk("t5_idle_cols", 64'(cols), 64'd0);
      chk("t5_idle_x", 64'(x), 64'd0);
    end
    start_scan();
    expect_pulse(one << 17, base + 48);
    wait_to(0);
    chk("t5_restart_cols", 64'(cols), 64'd1);

    // 6: reset asserted during SAMPLE with cells non-zero
    wait_to(50);
    chk("t6_cells_pre", 64'(cells), 64'(one << 17));
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);
    rst = 1'b1;
    #1;
    chk("t6_cells", 64'(cells), 64'd0);
    chk("t6_cols", 64'(cols), 64'd0);
    chk("t6_x", 64'(x), 64'd0);
    chk("t6_vld", 64'(cells_valid), 64'd0);
    @(negedge clk);
    ena = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
